memtrans_host: RTL and testbench

MEMTRANS_HOST -- requirements
Module: memtrans_host

---
 rtl/memtrans_pkg.sv | 83 ++++++++
 rtl/memtrans_if.sv | 33 +++
 rtl/memtrans_word_shifter.sv | 42 ++++
 rtl/memtrans_host.sv | 260 ++++++++++++++++++++++++++
 tb/tb_memtrans_host.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memtrans_pkg.sv
// memtrans host shared definitions
// command codes, status codes, FSM states
package memtrans_pkg;

   localparam logic [7:0] CMD_FLASH_WR = 8'h70;
   localparam logic [7:0] CMD_FLASH_RD = 8'h0F;
   localparam logic [7:0] CMD_ERASE    = 8'h38;
   localparam logic [7:0] CMD_RAM_WR   = 8'hF3;
   localparam logic [7:0] CMD_RAM_RD   = 8'h93;
   localparam logic [7:0] RSP_BUSY     = 8'hCC;
   localparam logic [7:0] RSP_DONE     = 8'h33;

   typedef enum logic [2:0] {
      ST_OK            = 3'd0,
      ST_ACK_MISMATCH  = 3'd1,
      ST_DATA_MISMATCH = 3'd2,
      ST_TIMEOUT       = 3'd3,
      ST_BAD_ARGS      = 3'd4,
      ST_PROTOCOL      = 3'd5
   } status_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SEND_CMD,
      S_SEND_META,
      S_WAIT_ACK,
      S_WR_FETCH,
      S_WR_SEND,
      S_RD_RECV,
      S_ERASE_WAIT,
      S_WAIT_SUM,
      S_FINISH
   } state_e;

   function automatic logic is_cmd(input logic [7:0] c);
      return c == CMD_FLASH_WR || c == CMD_FLASH_RD ||
             c == CMD_ERASE    || c == CMD_RAM_WR   ||
             c == CMD_RAM_RD;
   endfunction

   function automatic logic is_wr(input logic [7:0] c);
      return c == CMD_FLASH_WR || c == CMD_RAM_WR;
   endfunction

   function automatic logic is_rd(input logic [7:0] c);
      return c == CMD_FLASH_RD || c == CMD_RAM_RD;
   endfunction

   function automatic logic is_wide(input logic [7:0] c);
      return c == CMD_RAM_WR || c == CMD_RAM_RD;
   endfunction

   function automatic logic [7:0] meta_byte(
      input logic [21:0] s,
      input logic [21:0] e,
      input logic [2:0]  i
   );
      logic [7:0] b;
      b = 8'h00;
      unique case (i)
         3'd0:    b = s[7:0];
         3'd1:    b = s[15:8];
         3'd2:    b = {2'b00, s[21:16]};
         3'd3:    b = e[7:0];
         3'd4:    b = e[15:8];
         3'd5:    b = {2'b00, e[21:16]};
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   function automatic logic [7:0] meta_xor(
      input logic [21:0] s,
      input logic [21:0] e
   );
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 6; i++)
         x = x ^ meta_byte(s, e, 3'(i));
      return x;
   endfunction

endpackage

// File: rtl/memtrans_if.sv
// memtrans host request/data bus
// master = requester, slave = memtrans_host
interface memtrans_if;

   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_cmd;
   logic [21:0] req_start;
   logic [21:0] req_end;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_data;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        erase_tick;
   logic        done;
   logic [2:0]  status;

   modport master (
      output req_valid, req_cmd, req_start, req_end,
      output wr_valid, wr_data,
      input  req_ready, wr_ready, rd_valid, rd_data,
      input  erase_tick, done, status
   );

   modport slave (
      input  req_valid, req_cmd, req_start, req_end,
      input  wr_valid, wr_data,
      output req_ready, wr_ready, rd_valid, rd_data,
      output erase_tick, done, status
   );

endinterface

// File: rtl/memtrans_word_shifter.sv
// LSB-first word <-> byte shifter
// 2 bytes (narrow) or 4 bytes (wide) per word
module memtrans_word_shifter (
   input  logic        clk,
   input  logic        rst,
   input  logic        wide,
   input  logic        load,
   input  logic [31:0] load_word,
   input  logic        shift,
   input  logic        push,
   input  logic [7:0]  push_byte,
   output logic [7:0]  byte_out,
   output logic        last,
   output logic [31:0] push_word
);

   logic [31:0] word;
   logic [1:0]  cnt;

   assign byte_out  = word[7:0];
   assign last      = cnt == (wide ? 2'd3 : 2'd1);
   assign push_word = wide ? {push_byte, word[31:8]}
                           : {16'h0000, push_byte, word[15:8]};

   // word register and byte position
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word <= '0;
         cnt  <= '0;
      end else if (load) begin
         word <= load_word;
         cnt  <= '0;
      end else if (shift) begin
         word <= {8'h00, word[31:8]};
         cnt  <= last ? 2'd0 : cnt + 2'd1;
      end else if (push) begin
         word <= push_word;
         cnt  <= last ? 2'd0 : cnt + 2'd1;
      end
   end

endmodule

// File: rtl/memtrans_host.sv
// memtrans host: UART command/data engine
// for flash/RAM read, write and erase
module memtrans_host
   import memtrans_pkg::*;
#(
   parameter logic [7:0]  CHECKSUM_INIT  = 8'h23,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   memtrans_if.slave  h,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   input  logic [7:0] rx_data,
   input  logic       rx_ready
);

   state_e      state, state_n;
   status_e     stat, stat_n;
   logic        ph, ph_n;
   logic [2:0]  idx, idx_n;
   logic [7:0]  cmd, cmd_n;
   logic [7:0]  csum, csum_n;
   logic [21:0] beg_q, beg_n;
   logic [21:0] fin_q, fin_n;
   logic [21:0] rem, rem_n;
   logic [31:0] timer, timer_n;
   logic [31:0] rdat, rdat_n;
   logic        rdv, rdv_n;
   logic        tick, tick_n;

   logic        is_send, is_rx, send_done;
   logic [7:0]  meta_sum;
   logic        sh_load, sh_shift, sh_push;
   logic [31:0] sh_word;
   logic [7:0]  sh_byte;
   logic        sh_last;
   logic [31:0] sh_pword;

   memtrans_word_shifter u_shift (
      .clk       (clk),
      .rst       (rst),
      .wide      (is_wide(cmd)),
      .load      (sh_load),
      .load_word (sh_word),
      .shift     (sh_shift),
      .push      (sh_push),
      .push_byte (rx_data),
      .byte_out  (sh_byte),
      .last      (sh_last),
      .push_word (sh_pword)
   );

   assign is_send = state == S_SEND_CMD  ||
                    state == S_SEND_META ||
                    state == S_WR_SEND;
   assign is_rx   = state == S_WAIT_ACK   ||
                    state == S_RD_RECV    ||
                    state == S_ERASE_WAIT ||
                    state == S_WAIT_SUM;
   assign send_done = is_send && ph && !tx_busy;
   assign meta_sum  = CHECKSUM_INIT ^ meta_xor(beg_q, fin_q);

   assign tx_start     = is_send && !ph;
   assign h.req_ready  = state == S_IDLE;
   assign h.wr_ready   = state == S_WR_FETCH && h.wr_valid;
   assign h.rd_valid   = rdv;
   assign h.rd_data    = rdat;
   assign h.erase_tick = tick;
   assign h.done       = state == S_FINISH;
   assign h.status     = stat;

   // byte presented to the UART
   always_comb begin
      tx_data = 8'h00;
      unique case (1'b1)
         state == S_SEND_CMD:  tx_data = cmd;
         state == S_SEND_META: tx_data = meta_byte(beg_q, fin_q, idx);
         state == S_WR_SEND:   tx_data = sh_byte;
         default:              tx_data = 8'h00;
      endcase
   end

   // next state and datapath updates
   always_comb begin
      state_n  = state;
      stat_n   = stat;
      ph_n     = ph;
      idx_n    = idx;
      cmd_n    = cmd;
      csum_n   = csum;
      beg_n    = beg_q;
      fin_n    = fin_q;
      rem_n    = rem;
      timer_n  = '0;
      rdat_n   = rdat;
      rdv_n    = 1'b0;
      tick_n   = 1'b0;
      sh_load  = 1'b0;
      sh_shift = 1'b0;
      sh_push  = 1'b0;
      sh_word  = '0;

      if (is_send && !ph && tx_busy)
         ph_n = 1'b1;

      unique case (state)
         S_IDLE: begin
            if (h.req_valid) begin
               cmd_n   = h.req_cmd;
               beg_n   = h.req_start;
               fin_n   = h.req_end;
               rem_n   = h.req_end - h.req_start;
               ph_n    = 1'b0;
               idx_n   = '0;
               sh_load = 1'b1;
               if (h.req_start == h.req_end ||
                   !is_cmd(h.req_cmd)) begin
                  stat_n  = ST_BAD_ARGS;
                  state_n = S_FINISH;
               end else begin
                  state_n = S_SEND_CMD;
               end
            end
         end
         S_SEND_CMD: begin
            if (send_done) begin
               ph_n    = 1'b0;
               state_n = S_SEND_META;
            end
         end
         S_SEND_META: begin
            if (send_done) begin
               ph_n  = 1'b0;
               idx_n = idx + 3'd1;
               if (idx == 3'd5)
                  state_n = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (rx_ready) begin
               if (rx_data != meta_sum) begin
                  stat_n  = ST_ACK_MISMATCH;
                  state_n = S_FINISH;
               end else begin
                  csum_n = CHECKSUM_INIT;
                  if (is_wr(cmd))
                     state_n = S_WR_FETCH;
                  else if (is_rd(cmd))
                     state_n = S_RD_RECV;
                  else
                     state_n = S_ERASE_WAIT;
               end
            end
         end
         S_WR_FETCH: begin
            if (h.wr_valid) begin
               sh_load = 1'b1;
               sh_word = h.wr_data;
               ph_n    = 1'b0;
               state_n = S_WR_SEND;
            end
         end
         S_WR_SEND: begin
            if (send_done) begin
               ph_n   = 1'b0;
               csum_n = csum ^ sh_byte;
               if (!sh_last)
                  sh_shift = 1'b1;
               else if (rem == 22'd1)
                  state_n = S_WAIT_SUM;
               else begin
                  rem_n   = rem - 22'd1;
                  state_n = S_WR_FETCH;
               end
            end
         end
         S_RD_RECV: begin
            if (rx_ready) begin
               csum_n  = csum ^ rx_data;
               sh_push = 1'b1;
               if (sh_last) begin
                  rdv_n  = 1'b1;
                  rdat_n = sh_pword;
                  if (rem == 22'd1)
                     state_n = S_WAIT_SUM;
                  else
                     rem_n = rem - 22'd1;
               end
            end
         end
         S_ERASE_WAIT: begin
            if (rx_ready) begin
               if (rx_data == RSP_BUSY)
                  tick_n = 1'b1;
               else if (rx_data == RSP_DONE) begin
                  stat_n  = ST_OK;
                  state_n = S_FINISH;
               end else begin
                  stat_n  = ST_PROTOCOL;
                  state_n = S_FINISH;
               end
            end
         end
         S_WAIT_SUM: begin
            if (rx_ready) begin
               stat_n  = (rx_data == csum) ? ST_OK
                                           : ST_DATA_MISMATCH;
               state_n = S_FINISH;
            end
         end
         S_FINISH: state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase

      if (is_rx && !rx_ready) begin
         if (timer >= TIMEOUT_CYCLES - 32'd1) begin
            stat_n  = ST_TIMEOUT;
            state_n = S_FINISH;
         end else begin
            timer_n = timer + 32'd1;
         end
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         stat  <= ST_OK;
         ph    <= 1'b0;
         idx   <= '0;
         cmd   <= '0;
         csum  <= '0;
         beg_q <= '0;
         fin_q <= '0;
         rem   <= '0;
         timer <= '0;
         rdat  <= '0;
         rdv   <= 1'b0;
         tick  <= 1'b0;
      end else begin
         state <= state_n;
         stat  <= stat_n;
         ph    <= ph_n;
         idx   <= idx_n;
         cmd   <= cmd_n;
         csum  <= csum_n;
         beg_q <= beg_n;
         fin_q <= fin_n;
         rem   <= rem_n;
         timer <= timer_n;
         rdat  <= rdat_n;
         rdv   <= rdv_n;
         tick  <= tick_n;
      end
   end

endmodule

// File: tb/tb_memtrans_host.sv
// memtrans_host directed bench
// UART model, handshake drivers, checks
module tb_memtrans_host;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_ready = 1'b0;

   memtrans_if bus ();

   memtrans_host #(
      .CHECKSUM_INIT  (8'h23),
      .TIMEOUT_CYCLES (32'd1000)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .h        (bus),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_busy  (tx_busy),
      .rx_data  (rx_data),
      .rx_ready (rx_ready)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_fall = 0;
   int bcnt = 0;
   int done_cnt = 0;
   int tick_cnt = 0;
   int wrr_cnt = 0;
   logic [7:0]  txq[$];
   logic [31:0] rdq[$];

   logic [7:0] exp_ramwr [15] = '{
      8'hF3, 8'h10, 8'h00, 8'h00, 8'h12, 8'h00, 8'h00,
      8'h44, 8'h33, 8'h22, 8'h11,
      8'hDD, 8'hCC, 8'hBB, 8'hAA
   };
   logic [7:0] exp_flrd [7] = '{
      8'h0F, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00
   };

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_start && !tx_busy) begin
         txq.push_back(tx_data);
         tx_busy <= 1'b1;
         bcnt    <= 3;
      end else if (tx_busy) begin
         if (bcnt == 0) begin
            tx_busy   <= 1'b0;
            last_fall <= cyc;
         end else begin
            bcnt <= bcnt - 1;
         end
      end
   end

   always @(negedge clk) begin
      if (bus.done)       done_cnt <= done_cnt + 1;
      if (bus.erase_tick) tick_cnt <= tick_cnt + 1;
      if (bus.wr_ready)   wrr_cnt  <= wrr_cnt + 1;
      if (bus.rd_valid)   rdq.push_back(bus.rd_data);
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tk();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [7:0] c,
                      input logic [21:0] s,
                      input logic [21:0] e);
      tk();
      bus.req_valid = 1'b1;
      bus.req_cmd   = c;
      bus.req_start = s;
      bus.req_end   = e;
      tk();
      bus.req_valid = 1'b0;
   endtask

   task automatic rx(input logic [7:0] b);
      tk();
      rx_data  = b;
      rx_ready = 1'b1;
      tk();
      rx_ready = 1'b0;
   endtask

   task automatic wait_tx(input string tag, input int n);
      int k = 0;
      while (!(txq.size() >= n && !tx_busy) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(k < 3000), 32'd1);
      tk();
   endtask

   task automatic wr_word(input string tag,
                          input logic [31:0] w);
      int k = 0;
      tk();
      bus.wr_valid = 1'b1;
      bus.wr_data  = w;
      @(negedge clk);
      while (!bus.wr_ready && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(k < 3000), 32'd1);
      tk();
      bus.wr_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag,
                            output logic [2:0] st);
      int k = 0;
      @(negedge clk);
      while (!bus.done && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(k < 3000), 32'd1);
      st = bus.status;
   endtask

   initial begin
      logic [2:0] st;
      int d0;
      bus.req_valid = 1'b0;
      bus.req_cmd   = 8'h00;
      bus.req_start = '0;
      bus.req_end   = '0;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = '0;

      repeat (3) tk();
      chk("rst_tx_start", 32'(tx_start), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_wr_ready", 32'(bus.wr_ready), 0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 0);
      chk("rst_erase_tick", 32'(bus.erase_tick), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_status", 32'(bus.status), 0);
      rst = 1'b1;
      tk();
      chk("rst_req_ready", 32'(bus.req_ready), 1);

      txq.delete();
      req(8'hF3, 22'h10, 22'h12);
      wait_tx("ramwr_meta", 7);
      rx(8'h21);
      wr_word("ramwr_w0", 32'h11223344);
      wr_word("ramwr_w1", 32'hAABBCCDD);
      wait_tx("ramwr_data", 15);
      rx(8'h67);
      wait_done("ramwr_done", st);
      chk("ramwr_status", 32'(st), 0);
      chk("ramwr_ntx", txq.size(), 15);
      for (int i = 0; i < 15; i++)
         chk($sformatf("ramwr_tx%0d", i),
             32'(txq[i]), 32'(exp_ramwr[i]));
      chk("ramwr_wrready", wrr_cnt, 2);

      txq.delete();
      rdq.delete();
      req(8'h0F, 22'h100, 22'h101);
      wait_tx("flrd_meta", 7);
      for (int i = 0; i < 7; i++)
         chk($sformatf("flrd_tx%0d", i),
             32'(txq[i]), 32'(exp_flrd[i]));
      rx(8'h22);
      rx(8'h34);
      rx(8'h12);
      rx(8'h06);
      wait_done("flrd_done", st);
      chk("flrd_status", 32'(st), 2);
      chk("flrd_nrd", rdq.size(), 1);
      chk("flrd_word", rdq[0], 32'h00001234);

      txq.delete();
      req(8'h38, 22'h0, 22'h1);
      wait_tx("erase_meta", 7);
      rx(8'h22);
      rx(8'hCC);
      rx(8'hCC);
      rx(8'h33);
      wait_done("erase_done", st);
      chk("erase_status", 32'(st), 0);
      chk("erase_ticks", tick_cnt, 2);

      txq.delete();
      req(8'h93, 22'h0, 22'h4);
      wait_tx("to_meta", 7);
      wait_done("to_done", st);
      chk("to_status", 32'(st), 3);
      chk("to_latency", cyc - last_fall - 1, 1000);

      txq.delete();
      req(8'hF3, 22'h5, 22'h5);
      @(negedge clk);
      chk("bad_eq_done", 32'(bus.done), 1);
      chk("bad_eq_status", 32'(bus.status), 4);
      req(8'h55, 22'h0, 22'h3);
      @(negedge clk);
      chk("bad_cmd_done", 32'(bus.done), 1);
      chk("bad_cmd_status", 32'(bus.status), 4);
      repeat (10) tk();
      chk("bad_no_tx", txq.size(), 0);

      txq.delete();
      req(8'h70, 22'h0, 22'h2);
      wait_tx("ack_meta", 7);
      rx(8'h20);
      wait_done("ack_done", st);
      chk("ack_status", 32'(st), 1);

      txq.delete();
      req(8'h93, 22'h10, 22'h12);
      wait_tx("rr_meta", 7);
      rx(8'h21);
      rx(8'h01);
      rx(8'h02);
      tk();
      rst = 1'b0;
      #1;
      chk("rr_tx_start", 32'(tx_start), 0);
      chk("rr_tx_data", 32'(tx_data), 0);
      chk("rr_rd_data", bus.rd_data, 0);
      chk("rr_status", 32'(bus.status), 0);
      chk("rr_done", 32'(bus.done), 0);
      chk("rr_rd_valid", 32'(bus.rd_valid), 0);
      d0 = done_cnt;
      repeat (5) tk();
      chk("rr_no_done", done_cnt, d0);
      rst = 1'b1;
      tk();

      txq.delete();
      rdq.delete();
      req(8'h0F, 22'h100, 22'h101);
      wait_tx("post_meta", 7);
      rx(8'h22);
      rx(8'h34);
      rx(8'h12);
      rx(8'h05);
      wait_done("post_done", st);
      chk("post_status", 32'(st), 0);
      chk("post_nrd", rdq.size(), 1);
      chk("post_word", rdq[0], 32'h00001234);
      chk("post_ntx", txq.size(), 7);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
